// File: rtl/regfile_pkg.sv
// Shared types for the 32x32 register array, its write-side sequencer and
// the issue logic.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int SELECT_LEN = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [SELECT_LEN-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_entry_t;

  // One-hot register decode, used to build pending-write masks.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [SELECT_LEN-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small writeback FIFO. Entries are exposed oldest-first together with
// their valid bits, so the mask and bypass logic can scan them in age order.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        push_entry,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only trusted under entry_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Rotate storage into age order: index 0 is the head.
  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    assign entries[k]     = mem[rd_ptr + PW'(k)];
    assign entry_valid[k] = (count > CW'(k));
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Write-side master for the 32x32 register array. Buffers writeback
// results, issues one array write per cycle through a registered output
// stage and publishes a pending-write mask for RAW hazard stalls.
// Optional feature macro: WB_BYPASS_EN adds the fwd_* lookup ports.
module writeback_sequencer
  import regfile_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [SELECT_LEN-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_value,
  output logic                  rf_enable_n,
  output logic [SELECT_LEN-1:0] rf_store,
  output logic [XLEN-1:0]       rf_store_value,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CW-1:0]         occupancy
`ifdef WB_BYPASS_EN
  ,
  input  logic [SELECT_LEN-1:0] fwd_rs,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_value
`endif
);

  wb_entry_t        fifo_entries [DEPTH];
  logic [DEPTH-1:0] fifo_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  wb_entry_t        push_entry;
  logic             stage_valid;

  assign wb_ready   = !fifo_full && !reset;
  // Writes to R0 complete the handshake but are dropped here.
  assign push       = wb_valid && wb_ready && (wb_rd != '0);
  assign pop        = !fifo_empty;
  assign push_entry = '{rd: wb_rd, value: wb_value};
  // R0 is never enqueued, so a non-zero select doubles as the stage valid.
  assign stage_valid = (rf_store != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_entry  (push_entry),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (occupancy),
    .entries     (fifo_entries),
    .entry_valid (fifo_valid)
  );

  // Output stage: take the FIFO head every cycle, else idle on R0 keeping the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_enable_n    <= 1'b1;
      rf_store       <= '0;
      rf_store_value <= '0;
    end else begin
      rf_enable_n <= 1'b0;
      if (!fifo_empty) begin
        rf_store       <= fifo_entries[0].rd;
        rf_store_value <= fifo_entries[0].value;
      end else begin
        rf_store <= '0;
      end
    end
  end

  // Pending mask: every register with a buffered or in-flight write.
  always_comb begin
    pending_mask = '0;
    if (stage_valid) pending_mask = pending_mask | rd_onehot(rf_store);
    for (int k = 0; k < DEPTH; k++) begin
      if (fifo_valid[k]) pending_mask = pending_mask | rd_onehot(fifo_entries[k].rd);
    end
    pending_mask[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  // Bypass lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_value = '0;
    if (fwd_rs != '0) begin
      if (stage_valid && (rf_store == fwd_rs)) begin
        fwd_hit   = 1'b1;
        fwd_value = rf_store_value;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (fifo_valid[k] && (fifo_entries[k].rd == fwd_rs)) begin
          fwd_hit   = 1'b1;
          fwd_value = fifo_entries[k].value;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer against a queue-based model.
module tb_writeback_sequencer;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [SELECT_LEN-1:0] wb_rd;
  logic [XLEN-1:0]       wb_value;
  logic                  rf_enable_n;
  logic [SELECT_LEN-1:0] rf_store;
  logic [XLEN-1:0]       rf_store_value;
  logic [NUM_REGS-1:0]   pending_mask;
  logic [CW-1:0]         occupancy;
`ifdef WB_BYPASS_EN
  logic [SELECT_LEN-1:0] fwd_rs;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_value;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: queue of accepted writes not yet issued, plus the write on the bus.
  wb_entry_t m_fifo[$];
  bit        m_stage_v;
  wb_entry_t m_stage;
  logic      m_en_n;

  writeback_sequencer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_value       (wb_value),
    .rf_enable_n    (rf_enable_n),
    .rf_store       (rf_store),
    .rf_store_value (rf_store_value),
    .pending_mask   (pending_mask),
    .occupancy      (occupancy)
`ifdef WB_BYPASS_EN
    ,
    .fwd_rs         (fwd_rs),
    .fwd_hit        (fwd_hit),
    .fwd_value      (fwd_value)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [SELECT_LEN-1:0] m_store();
    return m_stage_v ? m_stage.rd : '0;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_mask();
    logic [NUM_REGS-1:0] m = '0;
    if (m_stage_v) m[m_stage.rd] = 1'b1;
    foreach (m_fifo[i]) m[m_fifo[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic bit m_ready();
    return m_fifo.size() < DEPTH;
  endfunction

  task automatic m_reset();
    m_fifo.delete();
    m_stage_v = 0;
    m_stage   = '0;
    m_en_n    = 1'b1;
  endtask

  // Youngest matching write, with the bus write considered oldest.
  task automatic m_fwd(input logic [SELECT_LEN-1:0] rs, output bit hit, output logic [XLEN-1:0] val);
    hit = 0;
    val = '0;
    if (rs != 0) begin
      if (m_stage_v && m_stage.rd == rs) begin hit = 1; val = m_stage.value; end
      foreach (m_fifo[i]) if (m_fifo[i].rd == rs) begin hit = 1; val = m_fifo[i].value; end
    end
  endtask

  // Drive one cycle of stimulus from a negedge, advance the model, return at next negedge.
  task automatic step(input bit v, input logic [SELECT_LEN-1:0] rd, input logic [XLEN-1:0] val);
    bit        xfer;
    wb_entry_t e;
    wb_valid = v;
    wb_rd    = rd;
    wb_value = val;
    xfer     = v && m_ready();
    @(posedge clk);
    m_en_n = 1'b0;
    if (m_fifo.size() > 0) begin
      m_stage   = m_fifo.pop_front();
      m_stage_v = 1;
    end else begin
      m_stage_v = 0;
    end
    if (xfer && rd != 0) begin
      e.rd    = rd;
      e.value = val;
      m_fifo.push_back(e);
    end
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_value = '0;
`ifdef WB_BYPASS_EN
    fwd_rs   = '0;
`endif
    m_reset();
    repeat (3) begin
      @(negedge clk);
      checks++; if (rf_enable_n !== 1'b1) begin failures++; $display("FAIL reset_en_n: got %b exp 1", rf_enable_n); end
      checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b exp 0", wb_ready); end
      checks++; if (rf_store !== '0 || rf_store_value !== '0) begin failures++; $display("FAIL reset_store: got %0d/%h exp 0/0", rf_store, rf_store_value); end
      checks++; if (pending_mask !== '0 || occupancy !== '0) begin failures++; $display("FAIL reset_mask_occ: got %h/%0d exp 0/0", pending_mask, occupancy); end
    end
    reset = 1'b0;
    #1;
    checks++; if (rf_enable_n !== 1'b1) begin failures++; $display("FAIL release_en_n: got %b exp 1", rf_enable_n); end
    #4;
    repeat (4) begin
      step(0, '0, '0);
      checks++; if (rf_enable_n !== m_en_n) begin failures++; $display("FAIL idle_en_n: got %b exp %b", rf_enable_n, m_en_n); end
      checks++; if (rf_store !== '0 || pending_mask !== '0) begin failures++; $display("FAIL idle_store_mask: got %0d/%h exp 0/0", rf_store, pending_mask); end
    end
  endtask

  task automatic test_single();
    checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b exp 1", wb_ready); end
    step(1, 5'd5, 32'hDEADBEEF);
    checks++; if (occupancy !== CW'(1) || rf_store !== '0) begin failures++; $display("FAIL single_e: got occ %0d store %0d exp 1/0", occupancy, rf_store); end
    checks++; if (pending_mask !== 32'h20) begin failures++; $display("FAIL single_mask_e: got %h exp 00000020", pending_mask); end
    step(0, '0, '0);
    checks++; if (rf_store !== 5'd5 || rf_store_value !== 32'hDEADBEEF) begin failures++; $display("FAIL single_issue: got %0d/%h exp 5/deadbeef", rf_store, rf_store_value); end
    checks++; if (pending_mask !== 32'h20 || occupancy !== '0) begin failures++; $display("FAIL single_mask_e1: got %h/%0d exp 00000020/0", pending_mask, occupancy); end
    step(0, '0, '0);
    checks++; if (rf_store !== '0 || rf_store_value !== 32'hDEADBEEF) begin failures++; $display("FAIL single_after: got %0d/%h exp 0/deadbeef", rf_store, rf_store_value); end
    checks++; if (pending_mask !== '0) begin failures++; $display("FAIL single_mask_e2: got %h exp 0", pending_mask); end
  endtask

  task automatic test_back_to_back();
    logic [SELECT_LEN-1:0] issued[$];
    logic [XLEN-1:0]       vals[5];
    for (int i = 0; i < 5; i++) vals[i] = $urandom;
    for (int i = 0; i < 9; i++) begin
      checks++; if (wb_ready !== m_ready()) begin failures++; $display("FAIL b2b_ready: got %b exp %b", wb_ready, m_ready()); end
      if (i < 5) step(1, SELECT_LEN'(i + 1), vals[i]);
      else       step(0, '0, '0);
      checks++; if (rf_store !== m_store() || occupancy !== CW'(m_fifo.size())) begin failures++; $display("FAIL b2b_cycle: got %0d/%0d exp %0d/%0d", rf_store, occupancy, m_store(), m_fifo.size()); end
      if (rf_store != 0) begin
        issued.push_back(rf_store);
        checks++; if (rf_store_value !== vals[rf_store - 1]) begin failures++; $display("FAIL b2b_value: rd %0d got %h exp %h", rf_store, rf_store_value, vals[rf_store - 1]); end
      end
    end
    checks++; if (issued.size() != 5) begin failures++; $display("FAIL b2b_count: got %0d exp 5", issued.size()); end
    foreach (issued[i]) begin
      checks++; if (issued[i] !== SELECT_LEN'(i + 1)) begin failures++; $display("FAIL b2b_order: slot %0d got %0d exp %0d", i, issued[i], i + 1); end
    end
  endtask

  task automatic test_rd_zero();
    checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready: got %b exp 1", wb_ready); end
    step(1, '0, 32'h1234);
    checks++; if (occupancy !== '0 || rf_store !== '0 || pending_mask !== '0) begin failures++; $display("FAIL rd0_e: got %0d/%0d/%h exp 0/0/0", occupancy, rf_store, pending_mask); end
    step(0, '0, '0);
    checks++; if (rf_store !== '0 || pending_mask !== '0) begin failures++; $display("FAIL rd0_e1: got %0d/%h exp 0/0", rf_store, pending_mask); end
  endtask

  task automatic test_same_rd();
    logic [XLEN-1:0] last_val;
    int              n7 = 0;
    step(1, 5'd7, 32'h11);
    step(1, 5'd7, 32'h22);
`ifdef WB_BYPASS_EN
    fwd_rs = 5'd7;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_value !== 32'h22) begin failures++; $display("FAIL same_fwd: got %b/%h exp 1/22", fwd_hit, fwd_value); end
    #4;
`endif
    if (rf_store == 5'd7) begin n7++; last_val = rf_store_value; end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, '0);
      checks++; if (rf_store !== m_store() || pending_mask !== m_mask()) begin failures++; $display("FAIL same_cycle: got %0d/%h exp %0d/%h", rf_store, pending_mask, m_store(), m_mask()); end
      if (rf_store == 5'd7) begin n7++; last_val = rf_store_value; end
    end
    checks++; if (n7 != 2 || last_val !== 32'h22) begin failures++; $display("FAIL same_issue: got %0d writes last %h exp 2 last 22", n7, last_val); end
  endtask

  task automatic test_random();
    bit              v;
    logic [XLEN-1:0] ev;
    bit              eh;
    for (int i = 0; i < 400; i++) begin
      checks++; if (wb_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready: cyc %0d got %b exp %b", i, wb_ready, m_ready()); end
      v = ($urandom_range(0, 3) != 0);
      step(v, SELECT_LEN'($urandom_range(0, 7)), $urandom);
      checks++;
      if (rf_store !== m_store() || (m_stage_v && rf_store_value !== m_stage.value)) begin
        failures++; $display("FAIL rnd_store: cyc %0d got %0d/%h exp %0d/%h", i, rf_store, rf_store_value, m_store(), m_stage.value);
      end
      checks++; if (pending_mask !== m_mask() || occupancy !== CW'(m_fifo.size())) begin failures++; $display("FAIL rnd_mask_occ: cyc %0d got %h/%0d exp %h/%0d", i, pending_mask, occupancy, m_mask(), m_fifo.size()); end
`ifdef WB_BYPASS_EN
      fwd_rs = SELECT_LEN'($urandom_range(0, 7));
      #1;
      m_fwd(fwd_rs, eh, ev);
      checks++; if (fwd_hit !== eh || (eh && fwd_value !== ev)) begin failures++; $display("FAIL rnd_fwd: rs %0d got %b/%h exp %b/%h", fwd_rs, fwd_hit, fwd_value, eh, ev); end
      #4;
`else
      m_fwd('0, eh, ev);
`endif
    end
    repeat (DEPTH + 2) step(0, '0, '0);
  endtask

  task automatic test_reset_midstream();
    step(1, 5'd1, 32'hA1);
    step(1, 5'd2, 32'hA2);
    step(1, 5'd3, 32'hA3);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    checks++; if (rf_enable_n !== 1'b1 || wb_ready !== 1'b0) begin failures++; $display("FAIL mid_en_ready: got %b/%b exp 1/0", rf_enable_n, wb_ready); end
    checks++; if (rf_store !== '0 || rf_store_value !== '0) begin failures++; $display("FAIL mid_store: got %0d/%h exp 0/0", rf_store, rf_store_value); end
    checks++; if (pending_mask !== '0 || occupancy !== '0) begin failures++; $display("FAIL mid_mask_occ: got %h/%0d exp 0/0", pending_mask, occupancy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, '0, '0);
      checks++; if (rf_store !== '0 || pending_mask !== '0 || occupancy !== '0) begin failures++; $display("FAIL mid_after: cyc %0d got %0d/%h/%0d exp 0/0/0", i, rf_store, pending_mask, occupancy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rd_zero();
    test_same_rd();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
